// File: rtl/counter_uni_param.sv
// counter_uni_param: up/down counter with limits, step, wrap/stop and sticky flags (optional prescaler via CNT_PRESCALE_EN)
module counter_uni_param #(
  parameter int W = 8
`ifdef CNT_PRESCALE_EN
  , parameter int PSW = 4
`endif
) (
  input  logic           clk,
  input  logic           _areset,
  input  logic           _load,
  input  logic           _sset,
  input  logic           _en,
  input  logic           _updown,
  input  logic           _wrapstop,
  input  logic           _clr_flag,
  input  logic [W-1:0]   preld_val,
  input  logic [W-1:0]   lim_lo,
  input  logic [W-1:0]   lim_hi,
  input  logic [W-1:0]   step,
`ifdef CNT_PRESCALE_EN
  input  logic [PSW-1:0] presc,
`endif
  output logic [W-1:0]   dcout,
  output logic           overflow,
  output logic           underflow,
  output logic           tc
);
  logic [W-1:0] dcout_d, dcout_q;
  logic         ovf_d, ovf_q, unf_d, unf_q;
  logic [W:0]   sum, lo_plus;
  logic         evt, act, fit_up, fit_dn, set_ovf, set_unf;
`ifdef CNT_PRESCALE_EN
  logic [PSW-1:0] psc_d, psc_q;
  // prescaler: counts enabled cycles, restarts on load/set and on each count event
  always_comb begin
    evt   = _en && psc_q == presc;
    psc_d = (_load || _sset) ? '0 : !_en ? psc_q : evt ? '0 : psc_q + 1'b1;
  end
  // prescaler register
  always_ff @(posedge clk or negedge _areset)
    if (!_areset) psc_q <= '0;
    else psc_q <= psc_d;
`else
  assign evt = _en;
`endif
  // next count and flags; W+1-bit compares avoid wraparound errors at the range ends
  always_comb begin
    sum     = {1'b0, dcout_q} + {1'b0, step};
    lo_plus = {1'b0, lim_lo} + {1'b0, step};
    fit_up  = sum <= {1'b0, lim_hi};
    fit_dn  = {1'b0, dcout_q} >= lo_plus;
    act     = !_load && !_sset && evt && lim_lo <= lim_hi && step != '0;
    set_ovf = act && _updown && !fit_up;
    set_unf = act && !_updown && !fit_dn;
    dcout_d = _load ? preld_val :
              _sset ? lim_hi :
              !act ? dcout_q :
              _updown ? (fit_up ? sum[W-1:0] : (_wrapstop ? lim_lo : lim_hi)) :
                        (fit_dn ? dcout_q - step : (_wrapstop ? lim_hi : lim_lo));
    ovf_d   = !_load && (set_ovf || (ovf_q && !_clr_flag));
    unf_d   = !_load && (set_unf || (unf_q && !_clr_flag));
  end
  // counter and sticky flag registers
  always_ff @(posedge clk or negedge _areset)
    if (!_areset) begin
      dcout_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      dcout_q <= dcout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  assign dcout     = dcout_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign tc        = _updown ? dcout_q == lim_hi : dcout_q == lim_lo;
endmodule
